// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronised input, mid-bit sampling driven by a
// single cycle counter, with one-cycle rx_valid / rx_err pulses per frame.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1085,
  parameter int HALF_BIT     = 542
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  localparam logic [15:0] HALF_CNT = 16'(HALF_BIT);
  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  logic        rxd_meta_q, rxd_s_q;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_err_q, rx_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxd_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // A start bit that is high again at its midpoint was only a glitch.
        if (cnt_q == HALF_CNT) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxd_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rxd_s_q;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (rxd_s_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = IDLE;
          end else begin
            rx_err_d = 1'b1;
            state_d  = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WAIT_HIGH: begin
        if (rxd_s_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a scaled bit period (217 clk/bit, 1085/5) so the
// full scenario list stays short; the line driver and pulse monitor live here.
module tb_uart_rx;

  localparam int CPB     = 217;
  localparam int HALF    = 108;
  localparam int GLITCH  = 60;
  localparam int LAT_EXP = 2 + HALF + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int long_cnt = 0;
  int last_valid_cyc = 0;
  int fall_cyc = 0;
  logic prev_valid = 1'b0;
  logic prev_err = 1'b0;
  logic [7:0] data_log[$];

  uart_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: logs every received byte and any over-long or overlapping pulse.
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      data_log.push_back(rx_data);
    end
    if (rx_err) err_cnt++;
    if (rx_valid && rx_err) both_cnt++;
    if ((rx_valid && prev_valid) || (rx_err && prev_err)) long_cnt++;
    prev_valid = rx_valid;
    prev_err   = rx_err;
  end

  task automatic drive(input logic b, input int n);
    rxd = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    fall_cyc = cyc;
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(d[i], CPB);
    drive(stop_bit, CPB);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got %h want 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", rx_valid); end
    checks++; if (rx_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", rx_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_single;
    int v0, e0, lat;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_byte(8'h5A, 1'b1);
    drive(1'b1, CPB);
    lat = last_valid_cyc - fall_cyc;
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("[TB] FAIL z_valid_count got %0d want 1", valid_cnt - v0); end
    checks++; if (rx_data !== 8'h5A) begin errors++; $display("[TB] FAIL z_data got %h want 5a", rx_data); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("[TB] FAIL z_err_count got %0d want 0", err_cnt - e0); end
    checks++; if (lat < LAT_EXP - 2 || lat > LAT_EXP + 2) begin errors++; $display("[TB] FAIL z_latency got %0d want %0d+-2", lat, LAT_EXP); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL z_busy_after got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int v0, e0, base;
    logic [7:0] exp_bytes[3];
    exp_bytes = '{8'h4F, 8'h54, 8'h53};
    v0 = valid_cnt;
    e0 = err_cnt;
    base = data_log.size();
    for (int i = 0; i < 3; i++) send_byte(exp_bytes[i], 1'b1);
    drive(1'b1, CPB);
    checks++; if (valid_cnt - v0 !== 3) begin errors++; $display("[TB] FAIL b2b_valid_count got %0d want 3", valid_cnt - v0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("[TB] FAIL b2b_err_count got %0d want 0", err_cnt - e0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (data_log.size() <= base + i) begin
        errors++; $display("[TB] FAIL b2b_byte%0d got none want %h", i, exp_bytes[i]);
      end else if (data_log[base + i] !== exp_bytes[i]) begin
        errors++; $display("[TB] FAIL b2b_byte%0d got %h want %h", i, data_log[base + i], exp_bytes[i]);
      end
    end
  endtask

  task automatic test_glitch;
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    drive(1'b0, 10);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL glitch_busy_mid got %b want 1", busy); end
    drive(1'b0, GLITCH - 10);
    drive(1'b1, 2 * GLITCH);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy_end got %b want 0", busy); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("[TB] FAIL glitch_valid_count got %0d want 0", valid_cnt - v0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("[TB] FAIL glitch_err_count got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_break;
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_byte(8'h45, 1'b0);
    drive(1'b0, 3 * CPB);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL break_busy_low got %b want 1", busy); end
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("[TB] FAIL break_err_count got %0d want 1", err_cnt - e0); end
    drive(1'b1, 2 * CPB);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL break_busy_high got %b want 0", busy); end
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("[TB] FAIL break_err_total got %0d want 1", err_cnt - e0); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("[TB] FAIL break_valid_count got %0d want 0", valid_cnt - v0); end
    checks++; if (rx_data !== 8'h53) begin errors++; $display("[TB] FAIL break_data_hold got %h want 53", rx_data); end
  endtask

  task automatic test_reset_midframe;
    int v0, e0;
    logic [7:0] aborted;
    aborted = 8'hB3;
    v0 = valid_cnt;
    e0 = err_cnt;
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(aborted[i], CPB);
    drive(aborted[4], CPB / 2);
    rst = 1'b1;
    rxd = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy got %b want 0", busy); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("[TB] FAIL rst_mid_data got %h want 00", rx_data); end
    drive(1'b1, 2 * CPB);
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("[TB] FAIL rst_mid_valid got %0d want 0", valid_cnt - v0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("[TB] FAIL rst_mid_err got %0d want 0", err_cnt - e0); end
    send_byte(8'h4E, 1'b1);
    drive(1'b1, CPB);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("[TB] FAIL rst_after_valid got %0d want 1", valid_cnt - v0); end
    checks++; if (rx_data !== 8'h4E) begin errors++; $display("[TB] FAIL rst_after_data got %h want 4e", rx_data); end
  endtask

  task automatic test_extremes;
    int v0, e0, base;
    v0 = valid_cnt;
    e0 = err_cnt;
    base = data_log.size();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    drive(1'b1, CPB);
    checks++; if (valid_cnt - v0 !== 2) begin errors++; $display("[TB] FAIL ext_valid_count got %0d want 2", valid_cnt - v0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("[TB] FAIL ext_err_count got %0d want 0", err_cnt - e0); end
    checks++;
    if (data_log.size() < base + 2) begin
      errors++; $display("[TB] FAIL ext_bytes got %0d bytes want 2", data_log.size() - base);
    end else if (data_log[base] !== 8'h00 || data_log[base + 1] !== 8'hFF) begin
      errors++; $display("[TB] FAIL ext_bytes got %h %h want 00 ff", data_log[base], data_log[base + 1]);
    end
    checks++; if (rx_data !== 8'hFF) begin errors++; $display("[TB] FAIL ext_data_hold got %h want ff", rx_data); end
  endtask

  task automatic test_pulse_shape;
    checks++; if (both_cnt !== 0) begin errors++; $display("[TB] FAIL pulse_overlap got %0d want 0", both_cnt); end
    checks++; if (long_cnt !== 0) begin errors++; $display("[TB] FAIL pulse_width got %0d long want 0", long_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_midframe();
    test_extremes();
    test_pulse_shape();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 1085, giving clock cycles per serial bit period.
REQ-002 The module SHALL have parameter HALF_BIT, default 542, giving clock cycles from the start-bit falling edge to the mid-start sample.
REQ-003 Port clk, input, 1 bit: the single system clock; all state SHALL change only on its rising edge.
REQ-004 Port rst, input, 1 bit: the reset, which SHALL be synchronous and active-high.
REQ-005 Port rxd, input, 1 bit: asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-006 Port rx_data, output, 8 bits: the last correctly framed byte received.
REQ-007 Port rx_valid, output, 1 bit: one-cycle pulse marking a new rx_data.
REQ-008 Port rx_err, output, 1 bit: one-cycle pulse marking a framing error (stop bit sampled low).
REQ-009 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-010 rxd SHALL pass through a two-flop synchronizer (rxd_s) before any use; both flops SHALL reset to 1.
REQ-011 The FSM SHALL have exactly the states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-012 IDLE: if rxd_s==0, go to START and clear the bit counter; otherwise stay in IDLE.
REQ-013 START: when the counter reaches HALF_BIT, sample rxd_s; if 0, go to DATA with counter=0 and bit_idx=0; if 1 (glitch), return to IDLE with no output pulse.
REQ-014 DATA: when the counter reaches CLKS_PER_BIT-1, store rxd_s into shift[bit_idx], clear the counter and increment bit_idx; after bit_idx 7, go to STOP.
REQ-015 STOP: when the counter reaches CLKS_PER_BIT-1, sample rxd_s; if 1, load rx_data from shift, pulse rx_valid and go to IDLE.
REQ-016 STOP: if the sample is 0, pulse rx_err, leave rx_data unchanged and go to WAIT_HIGH.
REQ-017 WAIT_HIGH: stay until rxd_s==1, then go to IDLE; a held-low line (break) SHALL produce exactly one rx_err.
REQ-018 rx_valid and rx_err SHALL each be high for exactly one clk cycle per frame and SHALL never be high together.
REQ-019 rx_data SHALL hold its value between rx_valid pulses.
REQ-020 The counter SHALL be at least 12 bits wide, count 0..CLKS_PER_BIT-1 and wrap to 0 at each sample point; it SHALL not overflow for default parameters.
REQ-021 Because the FSM returns to IDLE at mid-stop-bit, it SHALL accept a start edge arriving immediately after the stop bit (back-to-back frames).
REQ-022 rx_valid SHALL assert 2+HALF_BIT+9*CLKS_PER_BIT+1 cycles (±2) after the rxd falling edge of the start bit: about 10 310 cycles at default parameters.

Reset
REQ-023 While rst is high at a clk edge: FSM to IDLE, counter and bit_idx to 0, shift and rx_data to 8'h00, rx_valid/rx_err/busy to 0, synchronizer flops to 1.
REQ-024 Reset asserted mid-frame SHALL discard the partial byte and SHALL NOT generate rx_valid or rx_err.
REQ-025 After reset deasserts, the line SHALL be treated as idle; if rxd is low, reception SHALL begin as a start bit, per REQ-012.

Verification
REQ-026 Send 'Z' (8'h5A) at 1085 clk/bit -> rx_data==8'h5A, a single rx_valid pulse within the REQ-022 window, rx_err never high.
REQ-027 Send back-to-back 'O','T','S' (8'h4F, 8'h54, 8'h53) with no idle gap -> three rx_valid pulses, rx_data 8'h4F, 8'h54, 8'h53 in order.
REQ-028 Apply a 300-cycle low glitch on idle rxd -> FSM returns to IDLE, no rx_valid, no rx_err, busy low again by cycle ~545.
REQ-029 Send 8'h45 with the stop bit driven low, then hold rxd low for 3 bit periods -> exactly one rx_err, rx_data unchanged, busy stays high until rxd returns high.
REQ-030 Assert rst for 1 cycle during bit 4 of a frame, then send 8'h4E -> no pulse from the aborted frame, then rx_data==8'h4E with one rx_valid.
REQ-031 Send 8'h00 and 8'hFF -> rx_data 8'h00 then 8'hFF, each with one rx_valid, confirming all-zero and all-one data handling.
